// File: rtl/led_cube_pkg.sv
// Shared definitions for the LED cube scan scheduler: sync byte value and
// the state encodings of the receive and scan state machines.
package led_cube_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    RX_WAIT_SYNC = 2'd0,
    RX_LOAD      = 2'd1,
    RX_PENDING   = 2'd2
  } rx_state_t;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_DRIVE = 1'b1
  } scan_state_t;

  // Number of bytes needed to carry one frame of the given bit count.
  function automatic int frame_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/led_cube_layer_scan.sv
// Layer multiplexer: walks the layers in order, inserting an all-off blank
// gap before each layer, and flags the end of the last layer so the frame
// buffer can be swapped without tearing.
module led_cube_layer_scan
  import led_cube_pkg::*;
#(
  parameter int LAYERS = 6,
  parameter int COLS   = 36,
  parameter int DWELL  = 20000,
  parameter int BLANK  = 50
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [LAYERS*COLS-1:0] front,
  output logic [COLS-1:0]        col,
  output logic [LAYERS-1:0]      layer,
  output logic                   swap_strobe
);

  localparam int IW   = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(LAYERS - 1);
  localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK - 1);

  scan_state_t   state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [COLS-1:0] row;

  // Column pattern of the layer currently selected by idx.
  always_comb begin
    row = '0;
    for (int l = 0; l < LAYERS; l++) begin
      if (idx == IW'(l)) row = front[l*COLS +: COLS];
    end
  end

  // High on the clock edge that ends the DRIVE phase of the last layer.
  assign swap_strobe = enable && (state == SCAN_DRIVE) &&
                       (cnt == DWELL_END) && (idx == LAST_IDX);

  // Scan FSM; col/layer are registered from the current state, so they
  // follow the state with one cycle of latency and are zero in every BLANK.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state <= SCAN_BLANK;
      idx   <= '0;
      cnt   <= '0;
      col   <= '0;
      layer <= '0;
    end else begin
      case (state)
        SCAN_BLANK: begin
          col   <= '0;
          layer <= '0;
          if (cnt == BLANK_END) begin
            state <= SCAN_DRIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SCAN_DRIVE: begin
          col   <= row;
          layer <= LAYERS'(1) << idx;
          if (cnt == DWELL_END) begin
            state <= SCAN_BLANK;
            cnt   <= '0;
            idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= SCAN_BLANK;
          cnt   <= '0;
          idx   <= '0;
          col   <= '0;
          layer <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_cube_scan_sched.sv
// LED cube scan scheduler: receives frames from a UART byte stream into a
// back buffer and displays the front buffer layer by layer. The buffers are
// swapped only at the end of a complete scan.
module led_cube_scan_sched
  import led_cube_pkg::*;
#(
  parameter int LAYERS = 6,
  parameter int COLS   = 36,
  parameter int DWELL  = 20000,
  parameter int BLANK  = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              enable,
  output logic [COLS-1:0]   col,
  output logic [LAYERS-1:0] layer,
  output logic [7:0]        frame_cnt,
  output logic              sync_err
);

  localparam int NBITS  = LAYERS * COLS;
  localparam int NBYTES = frame_bytes(NBITS);
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

  rx_state_t         rx_state;
  logic [BW-1:0]     byte_idx;
  logic [NBYTES*8-1:0] back;
  logic [NBITS-1:0]  front;
  logic              accept;
  logic              swap_strobe;
  logic              swap_now;

  // Byte handshake: a byte transfers on a rising edge where rx_valid and
  // rx_ready are both high; rx_ready drops only while a completed frame
  // waits for the swap, so the sender simply holds its byte until then.
  assign rx_ready = (rx_state != RX_PENDING);
  assign accept   = rx_valid && rx_ready;

  // A held scan (enable low) never reaches its swap point, so swap at once.
  assign swap_now = (rx_state == RX_PENDING) && (swap_strobe || !enable);

  // Receive FSM: sync hunt, payload load into back buffer, swap wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state  <= RX_WAIT_SYNC;
      byte_idx  <= '0;
      back      <= '0;
      front     <= '0;
      frame_cnt <= '0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      case (rx_state)
        RX_WAIT_SYNC: begin
          if (accept) begin
            if (rx_data == SYNC_BYTE) begin
              rx_state <= RX_LOAD;
              byte_idx <= '0;
            end else begin
              sync_err <= 1'b1;
            end
          end
        end
        RX_LOAD: begin
          if (accept) begin
            back[{byte_idx, 3'b000} +: 8] <= rx_data;
            if (byte_idx == LAST_BYTE) begin
              rx_state  <= RX_PENDING;
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        RX_PENDING: begin
          if (swap_now) begin
            front    <= back[NBITS-1:0];
            rx_state <= RX_WAIT_SYNC;
          end
        end
        default: rx_state <= RX_WAIT_SYNC;
      endcase
    end
  end

  led_cube_layer_scan #(
    .LAYERS(LAYERS),
    .COLS  (COLS),
    .DWELL (DWELL),
    .BLANK (BLANK)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .front      (front),
    .col        (col),
    .layer      (layer),
    .swap_strobe(swap_strobe)
  );

endmodule

// File: tb/tb_led_cube_scan_sched.sv
// Directed bench for led_cube_scan_sched with a short dwell/blank so whole
// scans fit in a few dozen cycles. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_led_cube_scan_sched;

  localparam int LAYERS = 6;
  localparam int COLS   = 36;
  localparam int DWELL  = 10;
  localparam int BLANK  = 2;
  localparam int NB     = 27;

  logic              clk;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              enable;
  logic [COLS-1:0]   col;
  logic [LAYERS-1:0] layer;
  logic [7:0]        frame_cnt;
  logic              sync_err;

  int         compared;
  int         mismatched;
  int         sync_err_seen;
  logic [7:0] exp_fc;
  logic [215:0] zero_img;

  led_cube_scan_sched #(
    .LAYERS(LAYERS),
    .COLS  (COLS),
    .DWELL (DWELL),
    .BLANK (BLANK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .enable   (enable),
    .col      (col),
    .layer    (layer),
    .frame_cnt(frame_cnt),
    .sync_err (sync_err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (sync_err === 1'b1) sync_err_seen++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(input logic [7:0] seed, input int i);
    logic [7:0] ib;
    ib = 8'(i);
    return seed ^ (ib * 8'd29) ^ {ib[3:0], ib[7:4]};
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic put_byte(input logic [7:0] b);
    int g;
    rx_data  = b;
    rx_valid = 1'b1;
    g = 0;
    while (rx_ready !== 1'b1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (rx_ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL put_byte timeout: rx_ready=%b want 1", rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] seed, input bit uniform,
                            output logic [215:0] img);
    logic [7:0] b;
    img = '0;
    put_byte(8'hA5);
    for (int i = 0; i < NB; i++) begin
      b = uniform ? seed : pat(seed, i);
      img[i*8 +: 8] = b;
      put_byte(b);
    end
    rx_valid = 1'b0;
    exp_fc = exp_fc + 8'd1;
  endtask

  task automatic wait_swap(input string tag);
    int g;
    g = 0;
    while (rx_ready !== 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (rx_ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL %s swap timeout: rx_ready=%b want 1", tag, rx_ready);
    end
  endtask

  // Leaves the bench at the first blank cycle before layer 0.
  task automatic sync_frame_start(input string tag);
    int g;
    g = 0;
    while (layer !== 6'b100000 && g < 300) begin @(negedge clk); g++; end
    while (layer === 6'b100000 && g < 300) begin @(negedge clk); g++; end
    if (g >= 300) begin
      compared++;
      mismatched++;
      $display("FAIL %s sync timeout: layer=%b", tag, layer);
    end
  endtask

  // Entered at the first blank cycle; checks one full scan cycle by cycle.
  task automatic check_scan(input logic [215:0] img, input string tag);
    logic [5:0]  exp_l;
    logic [35:0] exp_c;
    for (int l = 0; l < LAYERS; l++) begin
      for (int b = 0; b < BLANK; b++) begin
        if (l > 0 || b > 0) @(negedge clk);
        compared++;
        if (layer !== 6'd0 || col !== 36'd0) begin
          mismatched++;
          $display("FAIL %s blank l%0d: layer=%b col=%h want 0/0", tag, l, layer, col);
        end
      end
      for (int d = 0; d < DWELL; d++) begin
        @(negedge clk);
        exp_l = 6'b1 << l;
        exp_c = img[l*COLS +: COLS];
        compared++;
        if (layer !== exp_l || col !== exp_c) begin
          mismatched++;
          $display("FAIL %s drive l%0d c%0d: layer=%b col=%h want %b/%h",
                   tag, l, d, layer, col, exp_l, exp_c);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    exp_fc = 8'd0;
    repeat (3) @(negedge clk);
    compared++;
    if (col !== 36'd0 || layer !== 6'd0) begin
      mismatched++;
      $display("FAIL reset outputs: layer=%b col=%h want 0/0", layer, col);
    end
    compared++;
    if (frame_cnt !== 8'd0 || sync_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset counters: frame_cnt=%0d sync_err=%b want 0/0", frame_cnt, sync_err);
    end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (rx_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset rx_ready: got %b want 1", rx_ready);
    end
    check_scan(zero_img, "reset_scan");
  endtask

  task automatic test_first_frame();
    logic [215:0] img;
    send_frame(8'hFF, 1'b1, img);
    compared++;
    if (frame_cnt !== 8'd1 || rx_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL first commit: frame_cnt=%0d rx_ready=%b want 1/0", frame_cnt, rx_ready);
    end
    wait_swap("first");
    sync_frame_start("first");
    check_scan(img, "first_scan");
  endtask

  task automatic test_sync_err();
    logic [215:0] img;
    int base;
    base = sync_err_seen;
    put_byte(8'h00);
    compared++;
    if (sync_err !== 1'b1) begin
      mismatched++;
      $display("FAIL sync_err after 0x00: got %b want 1", sync_err);
    end
    put_byte(8'h3C);
    compared++;
    if (sync_err !== 1'b1) begin
      mismatched++;
      $display("FAIL sync_err after 0x3C: got %b want 1", sync_err);
    end
    send_frame(8'h11, 1'b0, img);
    compared++;
    if (sync_err_seen - base !== 2) begin
      mismatched++;
      $display("FAIL sync_err pulse count: got %0d want 2", sync_err_seen - base);
    end
    compared++;
    if (frame_cnt !== exp_fc) begin
      mismatched++;
      $display("FAIL sync frame_cnt: got %0d want %0d", frame_cnt, exp_fc);
    end
    wait_swap("sync");
    sync_frame_start("sync");
    check_scan(img, "sync_scan");
  endtask

  task automatic test_back_to_back();
    logic [215:0] old_img, img;
    logic [35:0]  exp_c;
    bit           bad_layer;
    int           g;
    old_img = '0;
    for (int i = 0; i < NB; i++) old_img[i*8 +: 8] = pat(8'h11, i);
    g = 0;
    while (layer !== 6'b000100 && g < 300) begin @(negedge clk); g++; end
    send_frame(8'h5A, 1'b0, img);
    compared++;
    if (rx_ready !== 1'b0 || frame_cnt !== exp_fc) begin
      mismatched++;
      $display("FAIL b2b commit: rx_ready=%b frame_cnt=%0d want 0/%0d", rx_ready, frame_cnt, exp_fc);
    end
    g = 0;
    while (rx_ready !== 1'b1 && g < 200) begin
      exp_c = 36'd0;
      bad_layer = (layer != 6'd0) && ((layer & (layer - 6'd1)) != 6'd0);
      for (int l = 0; l < LAYERS; l++) if (layer === (6'b1 << l)) exp_c = old_img[l*COLS +: COLS];
      compared++;
      if (bad_layer || col !== exp_c) begin
        mismatched++;
        $display("FAIL b2b old front: layer=%b col=%h want col %h", layer, col, exp_c);
      end
      @(negedge clk);
      g++;
    end
    compared++;
    if (rx_ready !== 1'b1 || layer !== 6'b100000 || col !== old_img[5*COLS +: COLS]) begin
      mismatched++;
      $display("FAIL b2b swap point: rx_ready=%b layer=%b col=%h want 1/100000/%h",
               rx_ready, layer, col, old_img[5*COLS +: COLS]);
    end
    sync_frame_start("b2b");
    check_scan(img, "b2b_scan");
  endtask

  task automatic test_enable();
    logic [215:0] img;
    int g;
    g = 0;
    while (layer !== 6'b001000 && g < 300) begin @(negedge clk); g++; end
    enable = 1'b0;
    @(negedge clk);
    compared++;
    if (layer !== 6'd0 || col !== 36'd0) begin
      mismatched++;
      $display("FAIL enable off: layer=%b col=%h want 0/0", layer, col);
    end
    send_frame(8'hC3, 1'b0, img);
    compared++;
    if (rx_ready !== 1'b0 || frame_cnt !== exp_fc) begin
      mismatched++;
      $display("FAIL enable commit: rx_ready=%b frame_cnt=%0d want 0/%0d", rx_ready, frame_cnt, exp_fc);
    end
    @(negedge clk);
    compared++;
    if (rx_ready !== 1'b1 || layer !== 6'd0 || col !== 36'd0) begin
      mismatched++;
      $display("FAIL enable immediate swap: rx_ready=%b layer=%b col=%h want 1/0/0", rx_ready, layer, col);
    end
    enable = 1'b1;
    @(negedge clk);
    check_scan(img, "enable_restart");
  endtask

  task automatic test_reset_mid_load();
    logic [215:0] img;
    put_byte(8'hA5);
    for (int i = 0; i < 10; i++) put_byte(pat(8'h77, i));
    rx_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_fc = 8'd0;
    compared++;
    if (frame_cnt !== 8'd0 || rx_ready !== 1'b1 || layer !== 6'd0 || col !== 36'd0) begin
      mismatched++;
      $display("FAIL mid-load reset: frame_cnt=%0d rx_ready=%b layer=%b col=%h want 0/1/0/0",
               frame_cnt, rx_ready, layer, col);
    end
    @(negedge clk);
    check_scan(zero_img, "reset_cleared");
    send_frame(8'h96, 1'b0, img);
    compared++;
    if (frame_cnt !== 8'd1) begin
      mismatched++;
      $display("FAIL fresh load frame_cnt: got %0d want 1", frame_cnt);
    end
    wait_swap("fresh");
    sync_frame_start("fresh");
    check_scan(img, "fresh_scan");
  endtask

  task automatic test_wrap();
    logic [215:0] img;
    enable = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 256; k++) begin
      send_frame(8'(k), 1'b1, img);
      if (exp_fc == 8'd0) begin
        compared++;
        if (frame_cnt !== 8'd0) begin
          mismatched++;
          $display("FAIL wrap to zero: frame_cnt=%0d want 0", frame_cnt);
        end
      end
    end
    compared++;
    if (frame_cnt !== exp_fc) begin
      mismatched++;
      $display("FAIL after wrap: frame_cnt=%0d want %0d", frame_cnt, exp_fc);
    end
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    sync_err_seen = 0;
    zero_img = '0;
    test_reset();
    test_first_frame();
    test_sync_err();
    test_back_to_back();
    test_enable();
    test_reset_mid_load();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
